// File: rtl/alu_issue_sched.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_sched
// Description : Sends each decoded instruction to the single-cycle ALU or the
//               pipelined multiplier, sharing one write-back port. Detects
//               port collisions and RAW/WAW hazards against in-flight MULs.
//               Optional perf counters are enabled by ALU_ISSUE_SCHED_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_sched #(
    parameter int MUL_LAT = 4
) (
    input  logic        clk_i,
    input  logic        rsn_i,
    input  logic        valid_i,
    input  logic [31:0] instr_i,
    output logic        stall_o,
    output logic        alu_issue_o,
    output logic        mul_issue_o,
    output logic        wb_valid_o,
    output logic        wb_sel_o,
    output logic [4:0]  wb_rd_o
`ifdef ALU_ISSUE_SCHED_PERF_EN
    ,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] mul_cnt_o
`endif
);

    localparam logic [6:0] C_OP_REG    = 7'b0110011;
    localparam logic [6:0] C_OP_STORE  = 7'b0100011;
    localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] C_F7_MULDIV = 7'b0000001;
    localparam logic [2:0] C_F3_MUL    = 3'b000;

    logic [6:0] w_opcode;
    logic [4:0] w_rd;
    logic [2:0] w_funct3;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic [6:0] w_funct7;

    logic       w_is_mul;
    logic       w_writes;
    logic       w_uses_rs2;
    logic       w_collision;
    logic       w_raw;
    logic       w_waw;
    logic       w_stall;
    logic       w_alu_issue;
    logic       w_mul_issue;

    // Entry 0 is the multiply at write-back this cycle; entry MUL_LAT-1 is
    // the one issued last cycle.
    logic [MUL_LAT-1:0] r_vld;
    logic [4:0]         r_rd [MUL_LAT];

    logic       r_wb_valid;
    logic       r_wb_sel;
    logic [4:0] r_wb_rd;

    assign w_opcode = instr_i[6:0];
    assign w_rd     = instr_i[11:7];
    assign w_funct3 = instr_i[14:12];
    assign w_rs1    = instr_i[19:15];
    assign w_rs2    = instr_i[24:20];
    assign w_funct7 = instr_i[31:25];

    assign w_is_mul   = (w_opcode == C_OP_REG) && (w_funct3 == C_F3_MUL) &&
                        (w_funct7 == C_F7_MULDIV);
    assign w_writes   = (w_opcode != C_OP_STORE) && (w_opcode != C_OP_BRANCH) &&
                        (w_rd != 5'd0);
    assign w_uses_rs2 = (w_opcode == C_OP_REG) || (w_opcode == C_OP_STORE) ||
                        (w_opcode == C_OP_BRANCH);

    always_comb begin
        w_raw = 1'b0;
        w_waw = 1'b0;
        for (int i = 0; i < MUL_LAT; i++) begin
            if (r_vld[i]) begin
                if ((w_rs1 != 5'd0) && (w_rs1 == r_rd[i])) begin
                    w_raw = 1'b1;
                end
                if (w_uses_rs2 && (w_rs2 != 5'd0) && (w_rs2 == r_rd[i])) begin
                    w_raw = 1'b1;
                end
                if (w_writes && (w_rd == r_rd[i])) begin
                    w_waw = 1'b1;
                end
            end
        end
    end

    // Entry 1 reaches write-back next cycle, exactly when an ALU result would.
    assign w_collision = !w_is_mul && w_writes && r_vld[1];

    assign w_stall     = valid_i && (w_collision || w_raw || w_waw);
    assign w_alu_issue = valid_i && !w_stall && !rsn_i && !w_is_mul;
    assign w_mul_issue = valid_i && !w_stall && !rsn_i && w_is_mul;

    assign stall_o     = w_stall;
    assign alu_issue_o = w_alu_issue;
    assign mul_issue_o = w_mul_issue;

    always_ff @(posedge clk_i) begin
        if (rsn_i) begin
            r_vld <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                r_rd[i] <= 5'd0;
            end
        end else begin
            for (int i = 0; i < MUL_LAT - 1; i++) begin
                r_vld[i] <= r_vld[i+1];
                r_rd[i]  <= r_rd[i+1];
            end
            r_vld[MUL_LAT-1] <= w_mul_issue && w_writes;
            r_rd[MUL_LAT-1]  <= w_rd;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rsn_i) begin
            r_wb_valid <= 1'b0;
            r_wb_sel   <= 1'b0;
            r_wb_rd    <= 5'd0;
        end else if (w_alu_issue && w_writes) begin
            r_wb_valid <= 1'b1;
            r_wb_sel   <= 1'b0;
            r_wb_rd    <= w_rd;
        end else if (r_vld[1]) begin
            r_wb_valid <= 1'b1;
            r_wb_sel   <= 1'b1;
            r_wb_rd    <= r_rd[1];
        end else begin
            r_wb_valid <= 1'b0;
            r_wb_sel   <= 1'b0;
            r_wb_rd    <= 5'd0;
        end
    end

    assign wb_valid_o = r_wb_valid;
    assign wb_sel_o   = r_wb_sel;
    assign wb_rd_o    = r_wb_rd;

`ifdef ALU_ISSUE_SCHED_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_mul_cnt;

    always_ff @(posedge clk_i) begin
        if (rsn_i) begin
            r_stall_cnt <= 32'd0;
            r_mul_cnt   <= 32'd0;
        end else begin
            if (valid_i && w_stall) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_mul_issue) begin
                r_mul_cnt <= r_mul_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign mul_cnt_o   = r_mul_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_sched
// Description : Randomized scoreboard bench for alu_issue_sched with a
//               due-cycle reference model of pending write-backs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_sched;

    localparam int L       = 4;
    localparam int N_CYC   = 3000;
    localparam int N_DRAIN = L + 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [31:0] instr;
    logic        stall_o;
    logic        alu_issue_o;
    logic        mul_issue_o;
    logic        wb_valid_o;
    logic        wb_sel_o;
    logic [4:0]  wb_rd_o;

    alu_issue_sched #(.MUL_LAT(L)) dut (
        .clk_i       (clk),
        .rsn_i       (rst),
        .valid_i     (valid),
        .instr_i     (instr),
        .stall_o     (stall_o),
        .alu_issue_o (alu_issue_o),
        .mul_issue_o (mul_issue_o),
        .wb_valid_o  (wb_valid_o),
        .wb_sel_o    (wb_sel_o),
        .wb_rd_o     (wb_rd_o)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    logic rst_d = 1'b1;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_d <= rst;
    end

    typedef struct {
        int         due;
        logic       sel;
        logic [4:0] rd;
    } wb_t;

    typedef struct {
        int         due;
        logic [4:0] rd;
    } mul_t;

    wb_t  sb_q[$];
    mul_t infl[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] gen_instr();
        int         k   = $urandom_range(0, 9);
        logic [4:0] rd  = 5'($urandom_range(0, 7));
        logic [4:0] rs1 = 5'($urandom_range(0, 7));
        logic [4:0] rs2 = 5'($urandom_range(0, 7));
        logic [2:0] f3  = 3'($urandom_range(1, 7));
        logic [6:0] f7  = 7'($urandom);
        case (k)
            0, 1, 2, 3: return enc(7'b0000001, rs2, rs1, 3'b000, rd, 7'b0110011);
            4:          return enc(7'b0000000, rs2, rs1, f3, rd, 7'b0110011);
            5:          return enc(7'b0000001, rs2, rs1, f3, rd, 7'b0110011);
            6:          return enc(f7, rs2, rs1, 3'b000, rd, 7'b0010011);
            7:          return enc(f7, rs2, rs1, 3'b010, rd, 7'b0100011);
            8:          return enc(f7, rs2, rs1, 3'b000, rd, 7'b1100011);
            default:    return enc(f7, rs2, rs1, f3, rd, 7'b0110111);
        endcase
    endfunction

    function automatic void push_sorted(input wb_t e);
        int pos = sb_q.size();
        for (int i = 0; i < sb_q.size(); i++) begin
            if (sb_q[i].due > e.due) begin
                pos = i;
                break;
            end
        end
        sb_q.insert(pos, e);
    endfunction

    // Directed opening sequence: {valid, instruction}
    logic [32:0] dir_q[$];

    initial begin
        logic [32:0] cur;
        logic        hold;
        dir_q.push_back({1'b1, enc(7'd0, 5'd0, 5'd0, 3'd0, 5'd1, 7'b0110011)});
        dir_q.push_back({1'b1, enc(7'd0, 5'd0, 5'd0, 3'd0, 5'd2, 7'b0110011)});
        dir_q.push_back({1'b1, enc(7'd0, 5'd0, 5'd0, 3'd0, 5'd3, 7'b0110011)});
        dir_q.push_back({1'b1, enc(7'd1, 5'd2, 5'd1, 3'd0, 5'd5, 7'b0110011)});
        dir_q.push_back({1'b1, enc(7'd0, 5'd0, 5'd5, 3'd0, 5'd6, 7'b0110011)});
        dir_q.push_back({1'b1, enc(7'd1, 5'd2, 5'd1, 3'd0, 5'd5, 7'b0110011)});
        dir_q.push_back({1'b0, 32'd0});
        dir_q.push_back({1'b0, 32'd0});
        dir_q.push_back({1'b1, enc(7'd0, 5'd1, 5'd0, 3'd0, 5'd7, 7'b0010011)});
        dir_q.push_back({1'b1, enc(7'd1, 5'd2, 5'd1, 3'd0, 5'd8, 7'b0110011)});
        dir_q.push_back({1'b1, enc(7'd1, 5'd2, 5'd1, 3'd0, 5'd9, 7'b0110011)});
        dir_q.push_back({1'b1, enc(7'd1, 5'd2, 5'd1, 3'd0, 5'd10, 7'b0110011)});
        dir_q.push_back({1'b1, enc(7'd1, 5'd2, 5'd1, 3'd0, 5'd3, 7'b0110011)});
        dir_q.push_back({1'b1, enc(7'd0, 5'd5, 5'd1, 3'b010, 5'd0, 7'b0100011)});
        dir_q.push_back({1'b1, enc(7'd0, 5'd0, 5'd5, 3'b000, 5'd4, 7'b1100011)});
        dir_q.push_back({1'b1, enc(7'd1, 5'd2, 5'd1, 3'd0, 5'd0, 7'b0110011)});

        rst   = 1'b1;
        valid = 1'b0;
        instr = 32'd0;
        cur   = 33'd0;
        hold  = 1'b0;

        for (int n = 0; n < N_CYC + N_DRAIN; n++) begin
            logic       is_mul, writes, uses_rs2, coll, raw, waw;
            logic       e_stall, e_alu, e_mul;
            logic [6:0] op;
            logic [4:0] rd, rs1, rs2;

            @(posedge clk);
            #1;
            rst = (n < 3) || ((n > 60) && (n < N_CYC) && ($urandom_range(0, 99) == 0));
            if (!hold) begin
                if (n < 3 || n >= N_CYC) cur = 33'd0;
                else if (dir_q.size() > 0) cur = dir_q.pop_front();
                else cur = {($urandom_range(0, 9) < 8), gen_instr()};
            end
            valid = cur[32];
            instr = cur[31:0];

            // Reference model: pending multiplies tracked by their due cycle.
            while (infl.size() > 0 && infl[0].due < cyc) void'(infl.pop_front());
            op       = instr[6:0];
            rd       = instr[11:7];
            rs1      = instr[19:15];
            rs2      = instr[24:20];
            is_mul   = (op == 7'b0110011) && (instr[14:12] == 3'b000) &&
                       (instr[31:25] == 7'b0000001);
            writes   = (op != 7'b0100011) && (op != 7'b1100011) && (rd != 5'd0);
            uses_rs2 = (op == 7'b0110011) || (op == 7'b0100011) || (op == 7'b1100011);
            coll = 1'b0;
            raw  = 1'b0;
            waw  = 1'b0;
            foreach (infl[i]) begin
                if (!is_mul && writes && infl[i].due == cyc + 1) coll = 1'b1;
                if (rs1 != 5'd0 && rs1 == infl[i].rd) raw = 1'b1;
                if (uses_rs2 && rs2 != 5'd0 && rs2 == infl[i].rd) raw = 1'b1;
                if (writes && rd == infl[i].rd) waw = 1'b1;
            end
            e_stall = valid && (coll || raw || waw);
            e_alu   = valid && !e_stall && !rst && !is_mul;
            e_mul   = valid && !e_stall && !rst && is_mul;

            #1;
            check("issue{stall,alu,mul}", {29'd0, stall_o, alu_issue_o, mul_issue_o},
                  {29'd0, e_stall, e_alu, e_mul});

            if (rst) begin
                for (int i = infl.size() - 1; i >= 0; i--)
                    if (infl[i].due > cyc) infl.delete(i);
                for (int i = sb_q.size() - 1; i >= 0; i--)
                    if (sb_q[i].due > cyc) sb_q.delete(i);
            end else if (e_alu && writes) begin
                push_sorted('{due: cyc + 1, sel: 1'b0, rd: rd});
            end else if (e_mul && writes) begin
                push_sorted('{due: cyc + L, sel: 1'b1, rd: rd});
                infl.push_back('{due: cyc + L, rd: rd});
            end
            hold = e_stall && !rst;
        end

        @(negedge clk);
        #1;
        check("scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Write-back monitor, decoupled from stimulus.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_d) begin
                check("wb_after_reset", {25'd0, wb_valid_o, wb_sel_o, wb_rd_o}, 32'd0);
            end else if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                check("wb{valid,sel,rd}", {25'd0, wb_valid_o, wb_sel_o, wb_rd_o},
                      {25'd0, 1'b1, sb_q[0].sel, sb_q[0].rd});
                void'(sb_q.pop_front());
            end else begin
                check("wb_idle_valid", {31'd0, wb_valid_o}, 32'd0);
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/alu_issue_sched.md
# alu_issue_sched

Issue scheduler between decode and the execute stage. Each decoded instruction is steered to either the single-cycle integer ALU or a pipelined multi-cycle multiplier, and the two paths share one register-file write-back port. The block resolves write-back port collisions and RAW/WAW hazards against in-flight multiplies, stalls decode when needed, and drives the write-back select and destination register.

## Interface
- MUL_LAT, 4: multiplier latency in cycles, legal range 2..8.
- clk_i  in  1  clock; all state updates on the rising edge.
- rsn_i  in  1  reset. Synchronous, active-high.
- valid_i  in  1  decode presents an instruction; held stable while stall_o=1.
- instr_i  in  32  instruction word; opcode [6:0], rd [11:7], funct3 [14:12], rs1 [19:15], rs2 [24:20], funct7 [31:25].
- stall_o  out  1  combinational; decode must hold.
- alu_issue_o  out  1  combinational; instruction enters the ALU this cycle.
- mul_issue_o  out  1  combinational; instruction enters the multiplier this cycle.
- wb_valid_o  out  1  registered; register file write this cycle.
- wb_sel_o  out  1  registered; 0 = ALU result, 1 = multiplier result.
- wb_rd_o  out  5  registered; destination register.

## Operation
- Classification:
  - MUL: opcode 0110011, funct3 000, funct7 0000001.
  - Everything else is ALU class.
- Write classification:
  - Writes rd: any opcode except 0100011 (store) and 1100011 (branch), and rd != 0.
  - Uses rs2: opcodes 0110011, 0100011, 1100011. rs1 is always used.
- In-flight tracking:
  - MUL_LAT-entry shift structure; each entry holds valid and rd.
  - Issuing a writing MUL at cycle t fills the entry that reaches write-back at cycle t+MUL_LAT.
  - Non-writing MULs (rd=0) occupy no entry.
- Stall conditions, evaluated only when valid_i=1 (any one stalls):
  - Port collision: the instruction is ALU class and writes, and an in-flight MUL is due at write-back at t+1.
  - RAW: rs1 (or rs2 when used) is nonzero and equals the rd of any valid in-flight entry, including the entry at write-back this cycle.
  - WAW: the instruction writes and its rd equals the rd of any valid in-flight entry.
- Issue:
  - alu_issue_o = valid_i & ~stall_o & ALU class.
  - mul_issue_o = valid_i & ~stall_o & MUL class.
  - At most one issue per cycle.
- Write-back:
  - A writing ALU issue at t gives wb_valid_o=1, wb_sel_o=0, wb_rd_o=rd at t+1.
  - A writing MUL issue at t gives wb_valid_o=1, wb_sel_o=1, wb_rd_o=rd at t+MUL_LAT.
  - By construction, the two never coincide.
- Reset:
  - Clears all in-flight entries and the write-back registers.
  - Outputs after reset: stall_o, alu_issue_o, mul_issue_o follow the combinational rules with an empty tracker; wb_valid_o=0, wb_sel_o=0, wb_rd_o=0.
  - A reset mid-operation discards pending multiplies; no write-back is produced for them.

## Timing
- ALU path: issue at t, write-back at t+1.
- MUL path: issue at t, write-back at t+MUL_LAT.
- Back-to-back MULs may issue every cycle; up to MUL_LAT entries are valid at once.
- A RAW/WAW stall against a MUL issued at t holds through cycle t+MUL_LAT. The dependent instruction issues at t+MUL_LAT+1 at the earliest.
- A port collision stalls exactly one cycle per conflicting MUL.
- valid_i=0: no issue, stall_o=0, and the tracker still shifts.
- Simultaneous reset and valid_i: reset wins; nothing issues.

## Configuration
- ALU_ISSUE_SCHED_PERF_EN: when defined, adds two outputs, stall_cnt_o (32) and mul_cnt_o (32).
  - stall_cnt_o counts cycles with valid_i & stall_o.
  - mul_cnt_o counts mul_issue_o cycles.
  - Both counters clear on reset and wrap at 2^32.
- When not defined, neither the ports nor the counters exist, and behaviour is otherwise identical.

## Test plan
- MUL_LAT=4. Independent stream of add x1, add x2, add x3 in cycles 0..2 -> no stall; wb_valid_o at cycles 1..3, wb_sel_o=0, wb_rd_o = 1, 2, 3.
- mul x5,x1,x2 at cycle 0, then add x6,x5,x0 -> stall_o=1 in cycles 1..4; add issues at cycle 5; MUL write-back at cycle 4 (sel=1, rd=5); ALU write-back at cycle 6.
- mul x5 at cycle 0, then independent addi x7 offered at cycle 3 -> stall at cycle 3 (port collision); addi issues at cycle 4 and writes back at cycle 5; MUL writes back at cycle 4.
- mul x8, mul x9, mul x10 in cycles 0..2 -> no stalls; write-backs at cycles 4, 5, 6 with rd 8, 9, 10.
- mul x5 at cycle 0, reset asserted at cycle 2 -> wb_valid_o=0 at cycle 4; add x6,x5 offered after reset issues without stall.
- sw x5,0(x1) and beq x5,x0 each issued right after mul x3 -> no port-collision stall and no write-back for either; mul x0 issues and yields no write-back.
